alu_serial_rx: RTL
==================

Name: alu_serial_rx

Overview:
- Serial input deserializer for the mtm_Alu. Receives 11-bit frames on `sin`, assembles them into one ALU request: operands B and A plus a command byte.
- Checks framing, packet count, CRC-4 and opcode.
- Presents either a valid request or an error report to the ALU core, one pulse per transaction.

Parameters:
- TIMEOUT_CYCLES, 64: idle cycles mid-transaction before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock; `sin` sampled on rising edge
- rst_n  in  1  asynchronous active-low reset
- sin  in  1  serial input; idles high; one bit per clock
- b_o  out  32  operand B, from the first four data packets, MSB byte first
- a_o  out  32  operand A, from the next four data packets, MSB byte first
- op_o  out  3  opcode: 000 AND, 001 OR, 100 ADD, 101 SUB
- valid_o  out  1  one-cycle pulse: `a_o`/`b_o`/`op_o` hold a checked request
- err_o  out  1  one-cycle pulse: transaction rejected
- err_flags_o  out  3  {ERR_DATA, ERR_CRC, ERR_OP}; valid when `err_o`=1

Behaviour:
- Frame format, 11 bits, first bit on the wire first: start 0, type (0 = data, 1 = cmd), 8 payload bits MSB first, stop 1.
- Cmd payload: {1'b0, op[2:0], crc[3:0]}.
- Frame FSM states:
  - IDLE: wait for `sin`=0.
  - TYPE: latch type bit.
  - PAYLOAD: 8 cycles, payload bit counter 0..7.
  - STOP: check stop bit, then return to IDLE.
- A start bit is accepted in the cycle immediately after a stop bit; back-to-back frames need no gap.
- Data frame handling:
  - Shifts the payload into a 64-bit register {B,A}.
  - Increments the data counter, which saturates at 9.
- CRC:
  - Computed serially over 68 bits {B, A, 1'b1, op}.
  - Polynomial x^4+x+1, init 0, per bit d: fb=c[3]^d; c={c[2],c[1],c[0]^fb,fb}.
  - The CRC state and the data counter reset at the start of each transaction.
- Cmd frame check, on its valid stop bit, in priority order:
  1. Data counter != 8 -> ERR_DATA.
  2. Computed CRC != received crc -> ERR_CRC.
  3. Opcode not in {000,001,100,101} -> ERR_OP.
  - Only the highest-priority error flag is set.
- Stop bit sampled 0 on any frame:
  - Abort the transaction, report ERR_DATA, clear the counter.
  - Return to IDLE and wait for `sin` high before arming for a new start.
- Latency: `valid_o` or `err_o` asserts in the cycle after the cmd stop bit is sampled, for exactly one cycle. `valid_o` and `err_o` are never high together.
- Output data retention:
  - `a_o`, `b_o`, `op_o` update only with `valid_o` and hold their value afterwards.
  - `err_flags_o` updates only with `err_o` and holds its value afterwards.
- Reset (async, mid-frame included): all outputs 0, FSM to IDLE, counters and CRC cleared. A partially received transaction is discarded silently.

Optional Feature:
ALU_RX_TIMEOUT_EN
- Defined: a counter runs while the data counter > 0 and the FSM is in IDLE. It clears on any start bit.
- If the counter reaches TIMEOUT_CYCLES, the transaction is aborted with `err_o`=1, ERR_DATA; counters clear.
- Undefined: no timeout logic. A partial transaction waits indefinitely.

Test Plan:
- B=0, A=0, op=AND, crc=4'b1011 -> `valid_o` pulse one cycle after the last stop bit; `b_o`=0, `a_o`=0, `op_o`=000.
- B=0, A=0, op=ADD, crc=4'b0111 -> `valid_o`, `op_o`=100. Same request with crc=4'b0110 -> `err_o`, `err_flags_o`=010; `a_o`/`b_o`/`op_o` unchanged.
- B=20, A=10, op=ADD, CRC from the bench golden model, frames sent back-to-back with no idle gap -> `valid_o`, `b_o`=20, `a_o`=10.
- 7 data frames then a cmd with correct CRC -> `err_o`, `err_flags_o`=100. Opcode 010 with matching CRC -> `err_flags_o`=001.
- Stop bit forced to 0 in data frame 3 -> `err_o` with ERR_DATA. The following correct transaction -> `valid_o`.
- `rst_n` pulsed low mid-payload of data frame 5 -> outputs 0, no pulse. The next full transaction is accepted. With ALU_RX_TIMEOUT_EN: 4 data frames then idle 64 cycles -> `err_o`, ERR_DATA.

Source files
------------

// File: rtl/alu_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_rx
//  Description : Serial input deserializer for the mtm_Alu. Collects 11-bit
//                frames from sin, assembles {B, A, op}, checks framing,
//                packet count, CRC-4 and opcode, and reports either one
//                valid request or one error per transaction.
//                Optional macro ALU_RX_TIMEOUT_EN adds an idle timeout that
//                aborts a partially received transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_rx #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] b_o,
    output logic [31:0] a_o,
    output logic [2:0]  op_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [2:0]  err_flags_o
);

    localparam logic [2:0] ERR_DATA     = 3'b100;
    localparam logic [2:0] ERR_CRC      = 3'b010;
    localparam logic [2:0] ERR_OP       = 3'b001;
    localparam logic [3:0] DATA_FRAMES  = 4'd8;
    localparam logic [3:0] DATA_CNT_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TYPE    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_STOP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        armed;
    logic        is_cmd;
    logic [2:0]  bit_cnt;
    logic [7:0]  payload;
    logic [63:0] data_sr;
    logic [3:0]  data_cnt;
    logic [3:0]  crc;
    logic        start_bit;
    logic        tmo_fire;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_crc;
    logic        op_known;
    logic [2:0]  cmd_flags;

    // One serial step of the x^4+x+1 CRC
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    // A start bit only counts once the line has been seen high after a frame error
    assign start_bit = (state == S_IDLE) && armed && !sin;

    assign cmd_op  = payload[6:4];
    assign cmd_crc = payload[3:0];

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: start, type, 8 payload bits, stop
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_bit) state_nxt = S_TYPE;
            S_TYPE:    state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (bit_cnt == 3'd7) state_nxt = S_STOP;
            S_STOP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Arming: a good stop arms immediately, a bad stop waits for the line to go high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (state == S_STOP) begin
            armed <= sin;
        end else if ((state == S_IDLE) && sin) begin
            armed <= 1'b1;
        end
    end

    // Per-frame capture: type bit, payload shifter, operand shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_cmd  <= 1'b0;
            bit_cnt <= 3'd0;
            payload <= 8'd0;
            data_sr <= 64'd0;
        end else begin
            case (state)
                S_TYPE: begin
                    is_cmd  <= sin;
                    bit_cnt <= 3'd0;
                end
                S_PAYLOAD: begin
                    payload <= {payload[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (!is_cmd) begin
                        data_sr <= {data_sr[62:0], sin};
                    end
                end
                default: ;
            endcase
        end
    end

    // Transaction state: data frame count and running CRC over {B, A, 1, op}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt <= 4'd0;
            crc      <= 4'd0;
        end else if (tmo_fire) begin
            data_cnt <= 4'd0;
            crc      <= 4'd0;
        end else begin
            case (state)
                S_PAYLOAD: begin
                    if (!is_cmd) begin
                        crc <= crc_step(crc, sin);
                    end else if (bit_cnt == 3'd0) begin
                        // The always-zero cmd MSB slot stands in for the 1'b1 marker
                        crc <= crc_step(crc, 1'b1);
                    end else if (bit_cnt <= 3'd3) begin
                        crc <= crc_step(crc, sin);
                    end
                end
                S_STOP: begin
                    if (!sin || is_cmd) begin
                        data_cnt <= 4'd0;
                        crc      <= 4'd0;
                    end else if (data_cnt != DATA_CNT_MAX) begin
                        data_cnt <= data_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cmd frame verdict, highest-priority error only
    always_comb begin
        op_known  = (cmd_op == 3'b000) || (cmd_op == 3'b001) ||
                    (cmd_op == 3'b100) || (cmd_op == 3'b101);
        cmd_flags = 3'b000;
        if (data_cnt != DATA_FRAMES) begin
            cmd_flags = ERR_DATA;
        end else if (crc != cmd_crc) begin
            cmd_flags = ERR_CRC;
        end else if (!op_known) begin
            cmd_flags = ERR_OP;
        end
    end

    // Result pulses and held request / error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            err_flags_o <= 3'b000;
            b_o         <= 32'd0;
            a_o         <= 32'd0;
            op_o        <= 3'b000;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (tmo_fire) begin
                err_o       <= 1'b1;
                err_flags_o <= ERR_DATA;
            end else if (state == S_STOP) begin
                if (!sin) begin
                    err_o       <= 1'b1;
                    err_flags_o <= ERR_DATA;
                end else if (is_cmd) begin
                    if (cmd_flags != 3'b000) begin
                        err_o       <= 1'b1;
                        err_flags_o <= cmd_flags;
                    end else begin
                        valid_o <= 1'b1;
                        b_o     <= data_sr[63:32];
                        a_o     <= data_sr[31:0];
                        op_o    <= cmd_op;
                    end
                end
            end
        end
    end

`ifdef ALU_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_run;

    assign tmo_run  = (state == S_IDLE) && (data_cnt != 4'd0) && !start_bit;
    assign tmo_fire = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-gap counter inside a partially received transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!tmo_run || tmo_fire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

endmodule
`default_nettype wire
